// File: rtl/checkout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : checkout_pkg
//  Description : Shared types and default code tables for the UPC checkout
//                tally unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package checkout_pkg;

    // Transaction framing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Bit i set: code i is discounted. Implements P | (U & C), code = {U,P,C}.
    localparam logic [7:0] DISC_TABLE_DEF = 8'b1110_1100;

    // Bit i set: code i is expensive.
    localparam logic [7:0] EXP_TABLE_DEF  = 8'b1000_0011;

endpackage
`default_nettype wire

// File: rtl/upc_classify.sv
`default_nettype none
// ============================================================================
//  Module      : upc_classify
//  Description : Combinational per-item classifier. Looks the code up in the
//                discount and expensive tables; clearance forces a discount,
//                and a discounted item can never be flagged as stolen.
//  Revision    : 1.0 - initial release
// ============================================================================
module upc_classify
    import checkout_pkg::*;
#(
    parameter int                   UPC_W      = 3,
    parameter logic [2**UPC_W-1:0]  DISC_TABLE = DISC_TABLE_DEF,
    parameter logic [2**UPC_W-1:0]  EXP_TABLE  = EXP_TABLE_DEF
) (
    input  logic [UPC_W-1:0] upc,
    input  logic             marked,
    input  logic             clearance,
    output logic             disc,
    output logic             stolen
);

    // Table lookups; stolen requires expensive, unmarked and not discounted
    always_comb begin
        disc   = DISC_TABLE[upc] | clearance;
        stolen = EXP_TABLE[upc] & ~marked & ~disc;
    end

endmodule
`default_nettype wire

// File: rtl/upc_checkout.sv
`default_nettype none
// ============================================================================
//  Module      : upc_checkout
//  Description : Transaction tally unit. Frames a transaction with an
//                IDLE/ACTIVE/DONE FSM, keeps saturating item, discount and
//                stolen counts and pulses alarm once per stolen item.
//  Revision    : 1.0 - initial release
// ============================================================================
module upc_checkout
    import checkout_pkg::*;
#(
    parameter int                   UPC_W      = 3,
    parameter int                   CNT_W      = 8,
    parameter logic [2**UPC_W-1:0]  DISC_TABLE = DISC_TABLE_DEF,
    parameter logic [2**UPC_W-1:0]  EXP_TABLE  = EXP_TABLE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             scan,
    input  logic [UPC_W-1:0] upc,
    input  logic             marked,
    input  logic             finish,
    input  logic             clearance,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] item_cnt,
    output logic [CNT_W-1:0] disc_cnt,
    output logic [CNT_W-1:0] stolen_cnt,
    output logic             last_disc,
    output logic             alarm
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             clr_q, clr_d;
    logic [CNT_W-1:0] item_q, item_d;
    logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
    logic [CNT_W-1:0] stolen_q, stolen_d;
    logic             last_disc_q, last_disc_d;
    logic             alarm_q, alarm_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             item_disc;
    logic             item_stolen;

    // Classification uses the clearance bit latched at transaction start
    upc_classify #(
        .UPC_W      (UPC_W),
        .DISC_TABLE (DISC_TABLE),
        .EXP_TABLE  (EXP_TABLE)
    ) u_classify (
        .upc       (upc),
        .marked    (marked),
        .clearance (clr_q),
        .disc      (item_disc),
        .stolen    (item_stolen)
    );

    // Next-state logic: framing, counter clear/increment with saturation
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        item_d      = item_q;
        disc_cnt_d  = disc_cnt_q;
        stolen_d    = stolen_q;
        last_disc_d = last_disc_q;
        alarm_d     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // A scan arriving together with start is dropped
                if (start) begin
                    state_d     = ACTIVE;
                    clr_d       = clearance;
                    item_d      = '0;
                    disc_cnt_d  = '0;
                    stolen_d    = '0;
                    last_disc_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (scan) begin
                    if (item_q != CNT_MAX) item_d = item_q + 1'b1;
                    if (item_disc && (disc_cnt_q != CNT_MAX)) disc_cnt_d = disc_cnt_q + 1'b1;
                    if (item_stolen && (stolen_q != CNT_MAX)) stolen_d = stolen_q + 1'b1;
                    last_disc_d = item_disc;
                    alarm_d     = item_stolen;
                end
                // A scan in the same cycle as finish is still counted above
                if (finish) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ACTIVE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs, asynchronously cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            clr_q       <= 1'b0;
            item_q      <= '0;
            disc_cnt_q  <= '0;
            stolen_q    <= '0;
            last_disc_q <= 1'b0;
            alarm_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            item_q      <= item_d;
            disc_cnt_q  <= disc_cnt_d;
            stolen_q    <= stolen_d;
            last_disc_q <= last_disc_d;
            alarm_q     <= alarm_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign item_cnt   = item_q;
    assign disc_cnt   = disc_cnt_q;
    assign stolen_cnt = stolen_q;
    assign last_disc  = last_disc_q;
    assign alarm      = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_upc_checkout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_upc_checkout
//  Description : Scoreboard bench for upc_checkout. Two instances share the
//                stimulus (8-bit and 2-bit counters); a transaction-level
//                model predicts each cycle's outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upc_checkout;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, scan, marked, finish, clearance;
    logic [2:0] upc;

    logic       busy8, done8, last8, alarm8;
    logic [7:0] item8, disc8, stol8;
    logic       busy2, done2, last2, alarm2;
    logic [1:0] item2, disc2, stol2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    upc_checkout #(.UPC_W(3), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .scan(scan), .upc(upc),
        .marked(marked), .finish(finish), .clearance(clearance),
        .busy(busy8), .done(done8), .item_cnt(item8), .disc_cnt(disc8),
        .stolen_cnt(stol8), .last_disc(last8), .alarm(alarm8)
    );

    upc_checkout #(.UPC_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .scan(scan), .upc(upc),
        .marked(marked), .finish(finish), .clearance(clearance),
        .busy(busy2), .done(done2), .item_cnt(item2), .disc_cnt(disc2),
        .stolen_cnt(stol2), .last_disc(last2), .alarm(alarm2)
    );

    // Expected observable outputs after one clock edge (counts unbounded)
    typedef struct {
        bit busy;
        bit done;
        int items;
        int discs;
        int stolen;
        bit last;
        bit alarm;
    } exp_t;

    exp_t q[$];

    // Transaction-level reference model
    bit m_open, m_closed, m_clr, m_last, m_alarm;
    int m_items, m_discs, m_stolen;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_closed = 0; m_clr = 0; m_last = 0; m_alarm = 0;
        m_items = 0; m_discs = 0; m_stolen = 0;
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.busy = m_open; e.done = m_closed;
        e.items = m_items; e.discs = m_discs; e.stolen = m_stolen;
        e.last = m_last; e.alarm = m_alarm;
        return e;
    endfunction

    // Discount: P | (U & C) with code = {U,P,C}; expensive codes are 0, 1, 7
    task automatic model_step(input bit st, sc, input logic [2:0] c, input bit mk, fi, cl);
        bit d, s;
        m_alarm = 0;
        if (m_open) begin
            if (sc) begin
                d = m_clr | c[1] | (c[2] & c[0]);
                s = (c == 3'd0 || c == 3'd1 || c == 3'd7) && !mk && !d;
                m_items++;
                if (d) m_discs++;
                if (s) m_stolen++;
                m_last  = d;
                m_alarm = s;
            end
            if (fi) begin m_open = 0; m_closed = 1; end
        end else if (st) begin
            m_open = 1; m_closed = 0; m_clr = cl;
            m_items = 0; m_discs = 0; m_stolen = 0; m_last = 0;
        end
    endtask

    // One clock of stimulus: drive on the falling edge, predict the next edge
    task automatic drive(input bit st, sc, input logic [2:0] c, input bit mk, fi, cl);
        @(negedge clk);
        reset = 0; start = st; scan = sc; upc = c; marked = mk; finish = fi; clearance = cl;
        model_step(st, sc, c, mk, fi, cl);
        q.push_back(cur_exp());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"},  busy8,  0); chk({tag, " done"},  done8,  0);
        chk({tag, " item"},  item8,  0); chk({tag, " disc"},  disc8,  0);
        chk({tag, " stol"},  stol8,  0); chk({tag, " last"},  last8,  0);
        chk({tag, " alarm"}, alarm8, 0); chk({tag, " item2"}, item2,  0);
        chk({tag, " busy2"}, busy2,  0); chk({tag, " alarm2"}, alarm2, 0);
    endtask

    // Monitor: compare both instances against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("busy",       busy8,  e.busy);
                chk("done",       done8,  e.done);
                chk("item_cnt",   item8,  sat(e.items, 255));
                chk("disc_cnt",   disc8,  sat(e.discs, 255));
                chk("stolen_cnt", stol8,  sat(e.stolen, 255));
                chk("last_disc",  last8,  e.last);
                chk("alarm",      alarm8, e.alarm);
                chk("busy_w2",    busy2,  e.busy);
                chk("done_w2",    done2,  e.done);
                chk("item_w2",    item2,  sat(e.items, 3));
                chk("disc_w2",    disc2,  sat(e.discs, 3));
                chk("stolen_w2",  stol2,  sat(e.stolen, 3));
                chk("last_w2",    last2,  e.last);
                chk("alarm_w2",   alarm2, e.alarm);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; start = 0; scan = 0; upc = 0; marked = 0; finish = 0; clearance = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");

        // Scans in IDLE are ignored
        for (int i = 0; i < 4; i++) drive(0, 1, 3'(i), 0, 0, 0);

        // Codes 0..7 unmarked: 8 items, 5 discounted, 2 stolen
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 3'(i), 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Clearance: code 0 becomes discounted, never stolen
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0);
        // Scan with finish counted; scans in DONE ignored
        drive(0, 1, 1, 0, 1, 0);
        drive(0, 1, 7, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        // start with scan in DONE: counters clear, scan dropped
        drive(1, 1, 0, 0, 0, 0);

        // Five scans of code 2 saturate the 2-bit instance
        for (int i = 0; i < 5; i++) drive(0, 1, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);

        // Long transaction to saturate the 8-bit counters
        drive(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 270; i++) drive(0, 1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, 0);
        drive(0, 0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++)
            drive($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 60,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 5, 1'($urandom_range(0, 3) == 0));

        // Build counts 4/2/1 then assert reset between clock edges
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 2, 0, 0, 0);
        drive(0, 1, 3, 0, 0, 0);
        drive(0, 1, 4, 0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1; start = 0; scan = 0; finish = 0;
        model_reset();
        #1;
        check_zero("async_reset");
        q.push_back(cur_exp());
        // After release: IDLE ignores scans, start opens a transaction
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/upc_checkout.md
# upc_checkout

Sequential checkout tally unit for the UPC lab design. It extends single-item discount decoding to a whole transaction. A per-item classifier, driven by parameter tables, decides whether each item is discounted and whether it is stolen. A small FSM frames each transaction and keeps saturating counts of items, discounted items and stolen items, and raises a one-cycle alarm for each stolen item. It sits between the switch/key input conditioning and the HEX/LED display logic.

## Interface
Parameters:
- UPC_W, 3: width of the UPC code.
- CNT_W, 8: width of each tally counter.
- DISC_TABLE, 8'b1110_1100: 2**UPC_W bits; bit i = 1 means code i is discounted. The default implements P | (U & C) with code = {U,P,C}.
- EXP_TABLE, 8'b1000_0011: 2**UPC_W bits; bit i = 1 means code i is expensive.

Ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high.
- start, input, 1: open a new transaction.
- scan, input, 1: one-cycle strobe; upc and marked are valid in this cycle.
- upc, input, UPC_W: code of the scanned item.
- marked, input, 1: item carries a security mark (M).
- finish, input, 1: close the transaction.
- clearance, input, 1: clearance mode; sampled only on an accepted start.
- busy, output, 1: high while in ACTIVE.
- done, output, 1: high while in DONE.
- item_cnt, output, CNT_W: items scanned.
- disc_cnt, output, CNT_W: discounted items.
- stolen_cnt, output, CNT_W: stolen items.
- last_disc, output, 1: discount flag of the most recent accepted scan.
- alarm, output, 1: one-cycle pulse per stolen item.

## Operation
- FSM states IDLE, ACTIVE, DONE. On reset: state IDLE; all counters, last_disc, alarm, busy and done are 0; the latched clearance bit is 0.
- IDLE: start moves to ACTIVE. All other inputs are ignored.
- ACTIVE: each scan is accepted.
  - disc = DISC_TABLE[upc], or 1 if the latched clearance bit is 1.
  - stolen = EXP_TABLE[upc] & ~marked & ~disc. Discounted items are never stolen.
  - item_cnt increments by 1. disc_cnt increments if disc. stolen_cnt increments if stolen. last_disc is set to disc. alarm is set to stolen.
- ACTIVE + finish moves to DONE. If scan and finish are both high in the same cycle, the scan is counted, then the FSM moves to DONE. start is ignored in ACTIVE.
- DONE: counters hold for display; scan and finish are ignored. start moves to ACTIVE, clears all counters and last_disc, and latches clearance. start and scan together in DONE: the scan is dropped.
- IDLE + start also clears counters and latches clearance.
- Counters saturate at 2**CNT_W-1 and never wrap. Each counter saturates independently.
- alarm is high only in the cycle after an accepted stolen scan; otherwise it is 0.

## Timing
- All outputs are registered. A scan in cycle n is reflected in the counters, last_disc and alarm in cycle n+1.
- busy and done follow the state register: start in cycle n gives busy=1 in cycle n+1; finish in cycle n gives done=1 in cycle n+1.
- Counter clear on start is visible in cycle n+1.
- reset asserted mid-transaction immediately forces the reset values, including alarm=0, regardless of clk. Operation resumes on the first edge after reset deasserts, in IDLE.
- Back-to-back scan strobes, one per cycle, are each counted.

## Structure
- Package checkout_pkg: state_t enum {IDLE, ACTIVE, DONE}, plus default DISC_TABLE and EXP_TABLE constants.
- Sub-module upc_classify: purely combinational. Inputs: upc, marked, clearance. Outputs: disc, stolen. Parameterised by UPC_W, DISC_TABLE and EXP_TABLE. upc_checkout instantiates it once; it contains no state.
- upc_checkout holds the FSM, the clearance latch, three saturating counters, last_disc and the alarm register.

## Test plan
- Reset, then start, then scan codes 0..7 with marked=0 and defaults, then finish → item_cnt=8, disc_cnt=5, stolen_cnt=2 (codes 0 and 1), alarm pulsed in exactly 2 cycles, done=1.
- Start with clearance=1, then scan code 0 with marked=0 → disc_cnt=1, stolen_cnt=0, no alarm, last_disc=1.
- CNT_W=2: 5 scans of code 2 → item_cnt=3 and disc_cnt=3 (saturated, no wrap).
- Scan and finish in the same cycle, then a scan in DONE → the first scan is counted, the second is ignored, done=1. A following start clears all counters to 0.
- Scans while in IDLE → counters stay 0, alarm stays 0.
- reset asserted asynchronously mid-transaction with counts 4/2/1 → all outputs 0 before the next clk edge; FSM is in IDLE afterwards.
